// File: rtl/imem_access_arb.sv
// imem_access_arb: arbitrates one single-ported, word-organised, synchronous-read
// instruction memory between the fetch stage and a program loader.
// - Fetch has priority by default. A starvation counter forces a loader grant
//   after MAX_WAIT consecutive denied cycles.
// - ld_lock parks fetch (RUN -> DRAIN -> LOCKED) so the loader can do bulk loads.
// - Misaligned or out-of-range fetches are granted but never reach memory. They
//   come back as an error response.
// Optional build macro: IMEM_ARB_PERF_EN adds the perf_* event counters.
module imem_access_arb #(
  parameter int IMEM_SIZE = 1024,
  parameter int MAX_WAIT  = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           if_req,
  input  logic [31:0]                    if_addr,
  output logic                           if_gnt,
  output logic                           if_valid,
  output logic [31:0]                    if_rdata,
  output logic                           if_err,
  input  logic                           ld_req,
  input  logic [31:0]                    ld_addr,
  input  logic [31:0]                    ld_wdata,
  input  logic [3:0]                     ld_be,
  output logic                           ld_gnt,
  output logic                           ld_err,
  input  logic                           ld_lock,
  output logic                           lock_ack,
  output logic                           mem_en,
  output logic                           mem_we,
  output logic [$clog2(IMEM_SIZE/4)-1:0] mem_addr,
  output logic [31:0]                    mem_wdata,
  output logic [3:0]                     mem_be,
  input  logic [31:0]                    mem_rdata
`ifdef IMEM_ARB_PERF_EN
  ,
  output logic [31:0]                    perf_fetch_cnt,
  output logic [31:0]                    perf_load_cnt,
  output logic [31:0]                    perf_conflict_cnt
`endif
);

  localparam int          AW     = $clog2(IMEM_SIZE/4);
  localparam int          CW     = $clog2(MAX_WAIT+1);
  localparam logic [31:0] SIZE_L = IMEM_SIZE;

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_LOCKED} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_vld, r_err;
  logic [31:0]   r_hold;

  logic          w_if_bad, w_ld_bad, w_force;
  logic          w_if_win, w_ld_win;
  logic [31:0]   w_resp_data;
  logic          w_unused;

  // Low address bits of loader writes carry no information (word writes with byte enables).
  assign w_unused = &{1'b0, ld_addr[1:0]};

  assign w_if_bad = (if_addr[1:0] != 2'b00) || (if_addr >= SIZE_L);
  assign w_ld_bad = (ld_addr >= SIZE_L);
  assign w_force  = (r_cnt == CW'(MAX_WAIT));

  // Pick this cycle's winner. Nothing wins while reset is asserted, so every output reads 0.
  always_comb begin
    w_if_win = 1'b0;
    w_ld_win = 1'b0;
    if (rst_n) begin
      case (r_state)
        S_RUN: begin
          if (ld_req && (!if_req || w_force)) w_ld_win = 1'b1;
          else if (if_req)                    w_if_win = 1'b1;
        end
        // DRAIN and LOCKED: fetch is parked; the loader always gets through.
        default: w_ld_win = ld_req;
      endcase
    end
  end

  assign if_gnt   = w_if_win;
  assign ld_gnt   = w_ld_win;
  assign ld_err   = w_ld_win && w_ld_bad;
  assign lock_ack = (r_state == S_LOCKED);

  // Steer the winner onto the memory port. Rejected (bad-address) winners leave it idle.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (w_if_win && !w_if_bad) begin
      mem_en   = 1'b1;
      mem_addr = if_addr[AW+1:2];
    end else if (w_ld_win && !w_ld_bad) begin
      mem_en    = 1'b1;
      mem_we    = 1'b1;
      mem_addr  = ld_addr[AW+1:2];
      mem_wdata = ld_wdata;
      mem_be    = ld_be;
    end
  end

  // Lock sequencing and the loader starvation counter for the next cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    case (r_state)
      S_RUN: begin
        if (ld_lock) w_state_nxt = w_if_win ? S_DRAIN : S_LOCKED;
        if (ld_req && !w_ld_win) w_cnt_nxt = r_cnt + CW'(1);
      end
      S_DRAIN: begin
        if (!ld_lock)   w_state_nxt = S_RUN;
        else if (r_vld) w_state_nxt = S_LOCKED;
      end
      S_LOCKED: begin
        if (!ld_lock) w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_RUN;
    endcase
  end

  // State and starvation counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // The response lands one cycle after the grant. Errored fetches return zero data.
  assign w_resp_data = r_err ? 32'h0 : mem_rdata;
  assign if_valid    = r_vld;
  assign if_err      = r_vld && r_err;
  assign if_rdata    = r_vld ? w_resp_data : r_hold;

  // Track the outstanding fetch and keep the last returned word for the hold behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld  <= 1'b0;
      r_err  <= 1'b0;
      r_hold <= '0;
    end else begin
      r_vld <= w_if_win;
      r_err <= w_if_win && w_if_bad;
      if (r_vld) r_hold <= w_resp_data;
    end
  end

`ifdef IMEM_ARB_PERF_EN
  // Free-running event counters that wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt    <= '0;
      perf_load_cnt     <= '0;
      perf_conflict_cnt <= '0;
    end else begin
      if (w_if_win)         perf_fetch_cnt    <= perf_fetch_cnt + 32'd1;
      if (w_ld_win)         perf_load_cnt     <= perf_load_cnt + 32'd1;
      if (if_req && ld_req) perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imem_access_arb.sv
// Bench for imem_access_arb: directed vectors with literal checks, plus a
// transaction-level model that is compared against the DUT on every falling edge.
module tb_imem_access_arb;
  localparam int SZ = 1024;
  localparam int MW = 4;
  localparam int NW = SZ/4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0, ld_req = 1'b0, ld_lock = 1'b0;
  logic [31:0] if_addr = '0, ld_addr = '0, ld_wdata = '0;
  logic [3:0]  ld_be = '0;
  logic        if_gnt, if_valid, if_err, ld_gnt, ld_err, lock_ack;
  logic [31:0] if_rdata;
  logic        mem_en, mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = '0;

  int vectors = 0;
  int miscompares = 0;

  imem_access_arb #(.IMEM_SIZE(SZ), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid),
    .if_rdata(if_rdata), .if_err(if_err),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_be(ld_be),
    .ld_gnt(ld_gnt), .ld_err(ld_err), .ld_lock(ld_lock), .lock_ack(lock_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory attached to the DUT.
  logic [31:0] mem [NW];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++) if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= mem[mem_addr];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: the image of memory contents plus lock phase, denial streak and response slot.
  logic [31:0] img [NW];
  int          phase  = 0;        // 0 normal, 1 waiting for in-flight fetch, 2 locked
  int          streak = 0;
  bit          due = 0, derr = 0;
  logic [31:0] ddata = '0, last = '0;

  always @(negedge clk) begin
    bit          ldw, ifw, fbad, lbad, e_en, e_we;
    logic [31:0] e_addr, e_wd;
    logic [3:0]  e_be;
    int          nphase;
    if (!rst_n) begin
      chk("reset outputs", {if_gnt, if_valid, if_err, ld_gnt, ld_err, lock_ack, mem_en, mem_we, mem_be}, 32'h0);
      chk("reset if_rdata", if_rdata, 32'h0);
      chk("reset mem_addr/wdata", {24'h0, mem_addr} | mem_wdata, 32'h0);
      phase = 0; streak = 0; due = 0; derr = 0; ddata = '0; last = '0;
    end else begin
      fbad = (if_addr % 4 != 0) || (if_addr >= 32'(SZ));
      lbad = (ld_addr >= 32'(SZ));
      ldw  = ld_req && (phase != 0 || !if_req || streak >= MW);
      ifw  = (phase == 0) && if_req && !ldw;
      e_en = 0; e_we = 0; e_addr = 0; e_wd = 0; e_be = 0;
      if (ifw && !fbad) begin e_en = 1; e_addr = if_addr / 4; end
      if (ldw && !lbad) begin e_en = 1; e_we = 1; e_addr = ld_addr / 4; e_wd = ld_wdata; e_be = ld_be; end
      chk("if_gnt", if_gnt, ifw);
      chk("ld_gnt", ld_gnt, ldw);
      chk("ld_err", ld_err, ldw && lbad);
      chk("lock_ack", lock_ack, phase == 2);
      chk("mem_en", mem_en, e_en);
      chk("mem_we", mem_we, e_we);
      chk("mem_addr", mem_addr, e_addr);
      chk("mem_wdata", mem_wdata, e_wd);
      chk("mem_be", mem_be, e_be);
      chk("if_valid", if_valid, due);
      chk("if_err", if_err, due && derr);
      chk("if_rdata", if_rdata, due ? ddata : last);
      // advance to the next cycle
      streak = (phase == 0 && ld_req && !ldw) ? streak + 1 : 0;
      if (phase == 0)      nphase = ld_lock ? (ifw ? 1 : 2) : 0;
      else if (phase == 1) nphase = !ld_lock ? 0 : (due ? 2 : 1);
      else                 nphase = ld_lock ? 2 : 0;
      phase = nphase;
      if (due) last = ddata;
      due  = ifw;
      derr = ifw && fbad;
      if (ifw) ddata = fbad ? 32'h0 : img[if_addr / 4];
      if (ldw && !lbad)
        for (int b = 0; b < 4; b++) if (ld_be[b]) img[ld_addr / 4][8*b +: 8] = ld_wdata[8*b +: 8];
    end
  end

  // One stimulus cycle: inputs change just after the rising edge; return at the falling edge.
  task automatic cyc(input logic fr, input logic [31:0] fa, input logic lr, input logic [31:0] la,
                     input logic [31:0] wd, input logic [3:0] be, input logic lk);
    @(posedge clk); #1;
    if_req = fr; if_addr = fa; ld_req = lr; ld_addr = la; ld_wdata = wd; ld_be = be; ld_lock = lk;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  logic [31:0] atab [8];

  initial begin
    for (int i = 0; i < NW; i++) begin mem[i] = 32'hC0DE0000 | i; img[i] = 32'hC0DE0000 | i; end
    mem[6] = 32'h02408467; img[6] = 32'h02408467;
    atab[0] = 32'h0;   atab[1] = 32'h18;  atab[2] = 32'h24; atab[3] = 32'h40;
    atab[4] = 32'h1A;  atab[5] = 32'h400; atab[6] = 32'h3FC; atab[7] = 32'h1000;

    // reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("lit reset if_valid", if_valid, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // good fetch
    cyc(1, 32'h18, 0, 0, 0, 0, 0);
    chk("lit fetch gnt", if_gnt, 1);
    chk("lit fetch mem_addr", mem_addr, 6);
    idle();
    chk("lit fetch valid", if_valid, 1);
    chk("lit fetch data", if_rdata, 32'h02408467);
    chk("lit fetch err", if_err, 0);

    // misaligned and out-of-range fetches
    cyc(1, 32'h1A, 0, 0, 0, 0, 0);
    chk("lit misalign gnt", if_gnt, 1);
    chk("lit misalign mem_en", mem_en, 0);
    idle();
    chk("lit misalign err", {if_valid, if_err}, 2'b11);
    chk("lit misalign data", if_rdata, 0);
    cyc(1, 32'h400, 0, 0, 0, 0, 0);
    chk("lit range mem_en", {if_gnt, mem_en}, 2'b10);
    idle();
    chk("lit range err", {if_valid, if_err}, 2'b11);
    chk("lit range data", if_rdata, 0);

    // if_rdata holds once if_valid falls
    cyc(1, 32'h18, 0, 0, 0, 0, 0);
    idle();
    idle();
    chk("lit hold valid", if_valid, 0);
    chk("lit hold data", if_rdata, 32'h02408467);

    // starvation guard: the loader wins on the 5th contended cycle only
    for (int k = 0; k < 6; k++) begin
      cyc(1, 32'h18, 1, 32'h100, 32'hA5A50001, 4'hF, 0);
      chk("lit starve ld_gnt", ld_gnt, (k == 4));
      chk("lit starve if_gnt", if_gnt, (k != 4));
    end
    idle();

    // lock with a fetch in flight
    cyc(1, 32'h18, 0, 0, 0, 0, 1);
    chk("lit lockN gnt", {if_gnt, lock_ack}, 2'b10);
    cyc(1, 32'h18, 0, 0, 0, 0, 1);
    chk("lit lockN1", {if_valid, if_gnt, lock_ack}, 3'b100);
    cyc(1, 32'h18, 0, 0, 0, 0, 1);
    chk("lit lockN2", {if_gnt, lock_ack}, 2'b01);
    cyc(1, 32'h18, 1, 32'h24, 32'h4010e433, 4'hF, 1);
    chk("lit locked write", {ld_gnt, mem_we, if_gnt}, 3'b110);
    chk("lit locked addr", mem_addr, 9);
    cyc(1, 32'h18, 0, 0, 0, 0, 0);
    chk("lit unlock edge", {if_gnt, lock_ack}, 2'b01);
    cyc(1, 32'h24, 0, 0, 0, 0, 0);
    chk("lit resume", {if_gnt, lock_ack}, 2'b10);
    idle();
    chk("lit readback", if_rdata, 32'h4010e433);

    // out-of-range loader write
    cyc(0, 0, 1, 32'h1000, 32'hDEADBEEF, 4'hF, 0);
    chk("lit ld range", {ld_gnt, ld_err, mem_en}, 3'b110);
    idle();
    chk("lit ld_err pulse", ld_err, 0);

    // lock dropped while draining: lock_ack never rises
    cyc(1, 32'h18, 0, 0, 0, 0, 1);
    cyc(1, 32'h18, 0, 0, 0, 0, 0);
    chk("lit drain drop", {if_valid, if_gnt, lock_ack}, 3'b100);
    cyc(1, 32'h18, 0, 0, 0, 0, 0);
    chk("lit drain resume", {if_gnt, lock_ack}, 2'b10);
    idle();

    // partial byte-enable write; low address bits ignored
    cyc(0, 0, 1, 32'h43, 32'h11223344, 4'b0101, 0);
    cyc(1, 32'h40, 0, 0, 0, 0, 0);
    idle();
    chk("lit partial be", if_rdata, 32'hC0220044);

    // mixed traffic, checked by the model
    for (int k = 0; k < 48; k++)
      cyc(1'($urandom_range(0, 1)), atab[$urandom_range(0, 7)], 1'($urandom_range(0, 1)),
          atab[$urandom_range(0, 7)] & 32'hFFFF_FFFC, $urandom, 4'($urandom_range(0, 15)),
          (k >= 20 && k < 30));
    idle();

    // reset in the middle of a fetch
    cyc(1, 32'h18, 0, 0, 0, 0, 0);
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    chk("lit async reset", {if_gnt, if_valid, mem_en, lock_ack}, 4'b0000);
    chk("lit async reset data", if_rdata, 0);
    @(posedge clk); #1 rst_n = 1'b1; if_req = 1'b0;
    @(negedge clk);
    chk("lit no stale valid", if_valid, 0);
    idle();
    chk("lit no stale valid2", if_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/imem_access_arb.md
Name: imem_access_arb

Overview:
Two-requester arbiter and sequencer for a single-ported, word-organised, synchronous-read instruction memory. It sits between the core fetch stage and a program loader (debug/boot path), so the loader can write code into IMEM while the core runs or is held. It provides fetch-priority arbitration with a loader starvation guard, a lock handshake that parks fetch for bulk loading, and alignment and range checking.

Parameters:
IMEM_SIZE, 1024, IMEM size in bytes; must be a multiple of 4.
MAX_WAIT, 4, consecutive cycles a requesting loader may be denied before it is forced a grant; must be ≥1.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request
if_addr  in  32  fetch byte address
if_gnt  out  1  fetch accepted this cycle
if_valid  out  1  fetch response valid (one pulse per granted fetch)
if_rdata  out  32  fetch response instruction, little-endian word
if_err  out  1  response error, qualified by if_valid
ld_req  in  1  loader write request
ld_addr  in  32  loader byte address; bits [1:0] are ignored
ld_wdata  in  32  loader write data
ld_be  in  4  loader byte enables
ld_gnt  out  1  loader write accepted this cycle
ld_err  out  1  one-cycle pulse: out-of-range loader write dropped
ld_lock  in  1  loader requests exclusive access
lock_ack  out  1  exclusive access held (fetch blocked)
mem_en  out  1  memory enable
mem_we  out  1  memory write enable
mem_addr  out  $clog2(IMEM_SIZE/4)  word address
mem_wdata  out  32  memory write data
mem_be  out  4  memory byte enables
mem_rdata  in  32  memory read data, valid 1 cycle after mem_en && !mem_we

Behaviour:
- Reset (asynchronous, rst_n=0): all outputs 0; FSM to RUN; starvation counter 0; any outstanding read is discarded and no if_valid is produced for it.
- Grant logic is combinational and decided in the same cycle as the request. The mem_* outputs are driven combinationally from the winner. mem_* outputs are 0 when there is no winner.
- Default priority: fetch wins.
- Starvation counter increments on each cycle with ld_req && !ld_gnt. It clears on ld_gnt or when ld_req=0. When counter==MAX_WAIT, the loader wins that cycle and fetch is denied.
- Fetch response:
  - if_valid=1 exactly 1 cycle after if_gnt.
  - For a valid fetch: if_rdata=mem_rdata, if_err=0.
  - if_addr[1:0]≠0 or if_addr≥IMEM_SIZE: if_gnt still asserts but mem_en=0; next cycle if_valid=1, if_err=1, if_rdata=0.
  - if_rdata holds its last value when if_valid=0.
- Loader write:
  - ld_addr≥IMEM_SIZE: ld_gnt=1, mem_en=0, and ld_err pulses in the same cycle.
  - Otherwise: mem_en=mem_we=1, mem_addr=ld_addr[..:2], mem_be=ld_be.
- FSM states RUN, DRAIN, LOCKED:
  - RUN: normal arbitration. When ld_lock=1 (and not in reset), go to DRAIN if a fetch response is pending next cycle, else go to LOCKED.
  - DRAIN: no new fetch grants; the loader may still be granted. Go to LOCKED when the pending if_valid issues.
  - LOCKED: lock_ack=1; if_gnt=0; the loader is granted every cycle it requests; the starvation counter is held at 0. When ld_lock=0, return to RUN on the next cycle (lock_ack drops in the same transition).
  - ld_lock dropping while in DRAIN: return to RUN without asserting lock_ack.
- Simultaneous if_req and ld_req in the same cycle with counter<MAX_WAIT: fetch granted, loader waits.
- At most one request is outstanding: a single memory port means one access per cycle, so back-to-back fetch grants are allowed every cycle.

Optional Feature:
IMEM_ARB_PERF_EN
- Defined: adds outputs perf_fetch_cnt[31:0], perf_load_cnt[31:0] and perf_conflict_cnt[31:0].
  - perf_fetch_cnt counts if_gnt; perf_load_cnt counts ld_gnt; perf_conflict_cnt counts cycles with if_req && ld_req.
  - All three wrap at 2^32 and clear on reset.
- Undefined: these ports and the counter logic are absent; all other behaviour is identical.

Test Plan:
- if_req held, if_addr=0x18 with memory word 0x02408467 → if_gnt the same cycle; next cycle if_valid=1, if_rdata=0x02408467, if_err=0.
- if_addr=0x1A → if_gnt=1, mem_en=0; next cycle if_valid=1, if_err=1, if_rdata=0. Repeat with if_addr=0x400 → same error response.
- if_req and ld_req held continuously, MAX_WAIT=4 → ld_gnt first asserts on the 5th cycle; if_gnt=0 in that cycle; the counter returns to 0 afterwards.
- Fetch granted in cycle N, ld_lock rises in cycle N → DRAIN; if_valid in N+1; lock_ack=1 from N+2; if_req ignored while locked. Drop ld_lock → fetch grants resume.
- While LOCKED: write ld_addr=0x24, ld_wdata=0x4010e433, ld_be=4'hF → mem_we=1, mem_addr=9. After unlock, fetch 0x24 → if_rdata=0x4010e433.
- ld_addr=0x1000 → ld_gnt=1, ld_err pulses, mem_en=0. Assert rst_n=0 mid-fetch → all outputs 0 immediately; no stale if_valid after reset release.
